// File: rtl/bsg_manycore_link_fanout_if.sv
// bsg_manycore_link_fanout_if: core-side and per-link handshake bundle for bsg_manycore_link_fanout.
// Perf count signals exist only when BSG_MANYCORE_LINK_FANOUT_PERF_EN is defined.
interface bsg_manycore_link_fanout_if #(
    parameter int num_links_p    = 4,
    parameter int fwd_width_p    = 96,
    parameter int rev_width_p    = 40,
    parameter int y_cord_width_p = 7,
    parameter int max_credits_p  = 8
);
    localparam int iw = num_links_p > 1 ? $clog2(num_links_p) : 1;
    localparam int cw = $clog2(max_credits_p + 1);

    logic                               cfg_v_i;
    logic [iw-1:0]                      cfg_idx_i;
    logic [y_cord_width_p-1:0]          cfg_y_i;
    logic                               fwd_v_i;
    logic [fwd_width_p-1:0]             fwd_data_i;
    logic [y_cord_width_p-1:0]          fwd_y_i;
    logic                               fwd_ready_and_o;
    logic [num_links_p-1:0]             link_fwd_v_o;
    logic [num_links_p*fwd_width_p-1:0] link_fwd_data_o;
    logic [num_links_p-1:0]             link_fwd_ready_and_i;
    logic [num_links_p-1:0]             link_rev_v_i;
    logic [num_links_p*rev_width_p-1:0] link_rev_data_i;
    logic [num_links_p-1:0]             link_rev_ready_and_o;
    logic                               rev_v_o;
    logic [rev_width_p-1:0]             rev_data_o;
    logic                               rev_ready_and_i;
    logic                               route_miss_o;
    logic [num_links_p*cw-1:0]          credits_o;
`ifdef BSG_MANYCORE_LINK_FANOUT_PERF_EN
    logic [num_links_p*32-1:0]          perf_fwd_count_o;
    logic [31:0]                        perf_stall_count_o;
`endif

    modport master (
        output cfg_v_i, cfg_idx_i, cfg_y_i, fwd_v_i, fwd_data_i, fwd_y_i,
        output link_fwd_ready_and_i, link_rev_v_i, link_rev_data_i, rev_ready_and_i,
`ifdef BSG_MANYCORE_LINK_FANOUT_PERF_EN
        input  perf_fwd_count_o, perf_stall_count_o,
`endif
        input  fwd_ready_and_o, link_fwd_v_o, link_fwd_data_o, link_rev_ready_and_o,
        input  rev_v_o, rev_data_o, route_miss_o, credits_o
    );

    modport slave (
        input  cfg_v_i, cfg_idx_i, cfg_y_i, fwd_v_i, fwd_data_i, fwd_y_i,
        input  link_fwd_ready_and_i, link_rev_v_i, link_rev_data_i, rev_ready_and_i,
`ifdef BSG_MANYCORE_LINK_FANOUT_PERF_EN
        output perf_fwd_count_o, perf_stall_count_o,
`endif
        output fwd_ready_and_o, link_fwd_v_o, link_fwd_data_o, link_rev_ready_and_o,
        output rev_v_o, rev_data_o, route_miss_o, credits_o
    );
endinterface

// File: rtl/bsg_manycore_link_fanout.sv
// bsg_manycore_link_fanout: steers core requests to proc links by programmable y-coordinate with per-link
// credits, and round-robin merges link responses. Optional perf counters: BSG_MANYCORE_LINK_FANOUT_PERF_EN.
module bsg_manycore_link_fanout #(
    parameter int num_links_p    = 4,
    parameter int fwd_width_p    = 96,
    parameter int rev_width_p    = 40,
    parameter int y_cord_width_p = 7,
    parameter int max_credits_p  = 8
) (
    input logic clk_i,
    input logic reset_i,
    bsg_manycore_link_fanout_if.slave io
);
    localparam int iw = num_links_p > 1 ? $clog2(num_links_p) : 1;
    localparam int cw = $clog2(max_credits_p + 1);
    localparam logic [cw-1:0] max_cr = cw'(max_credits_p);

    logic [y_cord_width_p-1:0] tbl [num_links_p];
    logic [cw-1:0]             credit [num_links_p];
    logic [iw-1:0]             target, winner, rr_ptr;
    logic                      hit, any_rev, credit_ok, fwd_fire, can_load, grant;
    logic                      rev_v_r, route_miss_r;
    logic [rev_width_p-1:0]    rev_data_r;

    // Descending scan so the lowest matching index wins
    always_comb begin
        target = iw'(num_links_p - 1);
        hit = 1'b0;
        for (int i = num_links_p - 1; i >= 0; i--)
            if (tbl[i] == io.fwd_y_i) begin
                target = iw'(i);
                hit = 1'b1;
            end
    end

    always_comb begin
        winner = rr_ptr;
        any_rev = 1'b0;
        for (int k = num_links_p - 1; k >= 0; k--)
            if (io.link_rev_v_i[(int'(rr_ptr) + k) % num_links_p]) begin
                winner = iw'((int'(rr_ptr) + k) % num_links_p);
                any_rev = 1'b1;
            end
    end

    assign credit_ok = credit[target] != '0;
    assign fwd_fire  = io.fwd_v_i & io.fwd_ready_and_o;
    assign can_load  = ~reset_i & (~rev_v_r | io.rev_ready_and_i);
    assign grant     = can_load & any_rev;

    assign io.fwd_ready_and_o      = ~reset_i & credit_ok & io.link_fwd_ready_and_i[target];
    assign io.link_fwd_v_o         = (reset_i | ~io.fwd_v_i | ~credit_ok) ? '0 : num_links_p'(1) << target;
    assign io.link_fwd_data_o      = {num_links_p{io.fwd_data_i}};
    assign io.link_rev_ready_and_o = grant ? num_links_p'(1) << winner : '0;
    assign io.rev_v_o              = rev_v_r & ~reset_i;
    assign io.rev_data_o           = rev_data_r;
    assign io.route_miss_o         = route_miss_r;

    for (genvar g = 0; g < num_links_p; g++) begin : g_cr
        assign io.credits_o[g*cw +: cw] = credit[g];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < num_links_p; i++) begin
                tbl[i] <= y_cord_width_p'(i);
                credit[i] <= max_cr;
            end
            rr_ptr <= '0;
            rev_v_r <= 1'b0;
            route_miss_r <= 1'b0;
        end else begin
            if (io.cfg_v_i && int'(io.cfg_idx_i) < num_links_p)
                tbl[io.cfg_idx_i] <= io.cfg_y_i;
            if (fwd_fire && !hit)
                route_miss_r <= 1'b1;
            // A return and a send on the same link in one cycle cancel out
            for (int i = 0; i < num_links_p; i++) begin
                if ((grant && winner == iw'(i)) && !(fwd_fire && target == iw'(i)))
                    credit[i] <= (credit[i] == max_cr) ? max_cr : credit[i] + 1'b1;
                else if (!(grant && winner == iw'(i)) && (fwd_fire && target == iw'(i)))
                    credit[i] <= credit[i] - 1'b1;
            end
            if (can_load) begin
                rev_v_r <= any_rev;
                if (any_rev) begin
                    rev_data_r <= io.link_rev_data_i[winner*rev_width_p +: rev_width_p];
                    rr_ptr <= (winner == iw'(num_links_p - 1)) ? '0 : winner + 1'b1;
                end
            end
        end
    end

`ifdef BSG_MANYCORE_LINK_FANOUT_PERF_EN
    logic [31:0] fwd_cnt [num_links_p];
    logic [31:0] stall_cnt;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < num_links_p; i++)
                fwd_cnt[i] <= '0;
            stall_cnt <= '0;
        end else begin
            if (fwd_fire)
                fwd_cnt[target] <= fwd_cnt[target] + 1'b1;
            if (io.fwd_v_i && !io.fwd_ready_and_o && !credit_ok)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < num_links_p; g++) begin : g_perf
        assign io.perf_fwd_count_o[g*32 +: 32] = fwd_cnt[g];
    end
    assign io.perf_stall_count_o = stall_cnt;
`endif
endmodule
